// File: rtl/vector_load_unit.sv
// vector_load_unit: writer side of the 16 x VLEN-bit vector register file.
//   Fetches WORDS = VLEN/WORD_W consecutive memory words over a single-outstanding
//   request/valid port, packs them little-endian into one line, then issues one
//   register file write (RD/WD/wr_enable) with a coincident done pulse.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start, base_addr, dest_reg load request and its operands (sampled in IDLE only)
//   stride                    byte stride between words (only with VLOAD_STRIDE_EN)
//   busy, done                status: busy outside IDLE, done pulses with the write
//   mem_req, mem_addr         read request held until mem_rvalid, word byte address
//   mem_rdata, mem_rvalid     read response, may arrive in the same cycle as mem_req
//   RD, WD, wr_enable         register file write port, held between writes
// Configuration:
//   VLOAD_STRIDE_EN defined adds the stride input; otherwise words are contiguous
//   (stride fixed at WORD_W/8 bytes).
module vector_load_unit #(
  parameter int VLEN       = 192,
  parameter int WORD_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [REG_ADDR_W-1:0] dest_reg,
`ifdef VLOAD_STRIDE_EN
  input  logic [ADDR_W-1:0]     stride,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  mem_req,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [WORD_W-1:0]     mem_rdata,
  input  logic                  mem_rvalid,
  output logic [REG_ADDR_W-1:0] RD,
  output logic [VLEN-1:0]       WD,
  output logic                  wr_enable
);

  localparam int WORDS = VLEN / WORD_W;
  // idx must be able to count one past the last word without trouble
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic [REG_ADDR_W-1:0]   dest_q, dest_d;
  logic [VLEN-1:0]         line_q, line_d;
  logic [REG_ADDR_W-1:0]   rd_q, rd_d;
  logic [VLEN-1:0]         wd_q, wd_d;
  logic [ADDR_W-1:0]       stride_eff;

`ifdef VLOAD_STRIDE_EN
  logic [ADDR_W-1:0]       stride_q, stride_d;
  assign stride_eff = stride_q;
`else
  localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(WORD_W / 8);
  assign stride_eff = WORD_BYTES;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      base_q   <= '0;
      dest_q   <= '0;
      line_q   <= '0;
      rd_q     <= '0;
      wd_q     <= '0;
`ifdef VLOAD_STRIDE_EN
      stride_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      base_q   <= base_d;
      dest_q   <= dest_d;
      line_q   <= line_d;
      rd_q     <= rd_d;
      wd_q     <= wd_d;
`ifdef VLOAD_STRIDE_EN
      stride_q <= stride_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    base_d   = base_q;
    dest_d   = dest_q;
    line_d   = line_q;
    rd_d     = rd_q;
    wd_d     = wd_q;
`ifdef VLOAD_STRIDE_EN
    stride_d = stride_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d   = base_addr;
          dest_d   = dest_reg;
          idx_d    = '0;
`ifdef VLOAD_STRIDE_EN
          stride_d = stride;
`endif
          state_d  = FETCH;
        end
      end
      FETCH: begin
        if (mem_rvalid) begin
          line_d[int'(idx_q)*WORD_W +: WORD_W] = mem_rdata;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            // Snapshot the completed line (including the word arriving now) into
            // the write-port registers so WD/RD stay put until the next write.
            rd_d    = dest_q;
            wd_d    = line_d;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Address arithmetic is plain ADDR_W-bit, so it wraps silently past the top.
  assign mem_addr  = base_q + ADDR_W'(idx_q) * stride_eff;
  assign busy      = (state_q != IDLE);
  assign mem_req   = (state_q == FETCH);
  assign wr_enable = (state_q == WRITE);
  assign done      = (state_q == WRITE);
  assign RD        = rd_q;
  assign WD        = wd_q;

endmodule

// File: tb/tb_vector_load_unit.sv
module tb_vector_load_unit;
  localparam int VLEN       = 192;
  localparam int WORD_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int REG_ADDR_W = 4;
  localparam int WORDS      = VLEN / WORD_W;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic [ADDR_W-1:0]     base_addr = '0;
  logic [REG_ADDR_W-1:0] dest_reg = '0;
`ifdef VLOAD_STRIDE_EN
  logic [ADDR_W-1:0]     stride = 32'd4;
`endif
  logic                  busy, done, mem_req, wr_enable;
  logic [ADDR_W-1:0]     mem_addr;
  logic [WORD_W-1:0]     mem_rdata = '0;
  logic                  mem_rvalid = 1'b0;
  logic [REG_ADDR_W-1:0] RD;
  logic [VLEN-1:0]       WD;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference view of the write port: what RD/WD should currently hold.
  logic [REG_ADDR_W-1:0] last_rd = '0;
  logic [VLEN-1:0]       last_wd = '0;

  vector_load_unit #(
    .VLEN(VLEN), .WORD_W(WORD_W), .ADDR_W(ADDR_W), .REG_ADDR_W(REG_ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .dest_reg(dest_reg),
`ifdef VLOAD_STRIDE_EN
    .stride(stride),
`endif
    .busy(busy), .done(done), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .RD(RD), .WD(WD), .wr_enable(wr_enable)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory contents are a fixed function of address (plus a per-load salt),
  // so repeated addresses return repeated data.
  function automatic logic [WORD_W-1:0] mem_word(input logic [ADDR_W-1:0] a, input logic [31:0] salt);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  // One complete load, called and returning at a negedge with the DUT idle.
  // maxwait >= 0: random 0..maxwait wait cycles per word; maxwait < 0: exactly -maxwait.
  // abort_at >= 0: assert reset once that many words have been captured.
  task automatic run_load(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] strd,
                          input logic [REG_ADDR_W-1:0] dest, input int maxwait,
                          input bit hold_start, input int abort_at);
    logic [ADDR_W-1:0] addr [WORDS];
    int                wt   [WORDS];
    logic [VLEN-1:0]   exp_wd;
    logic [31:0]       salt;
    int exp_cyc, cyc, w, waited;

    salt    = $urandom;
    exp_wd  = '0;
    exp_cyc = 1;
    for (int i = 0; i < WORDS; i++) begin
      addr[i] = base + ADDR_W'(i) * strd;
      exp_wd[i*WORD_W +: WORD_W] = mem_word(addr[i], salt);
      wt[i] = (maxwait < 0) ? -maxwait : int'($urandom_range(0, maxwait));
      exp_cyc += wt[i] + 1;
    end

    chk("idle_before_start", busy, 0);
    start     = 1'b1;
    base_addr = base;
    dest_reg  = dest;
`ifdef VLOAD_STRIDE_EN
    stride    = strd;
`endif
    @(posedge clk); @(negedge clk);
    if (!hold_start) start = 1'b0;
    // Operands were captured; scribbling on them now must not matter.
    base_addr = $urandom;
    dest_reg  = REG_ADDR_W'($urandom);
`ifdef VLOAD_STRIDE_EN
    stride    = $urandom;
`endif
    cyc = 1; w = 0; waited = 0;
    while (w < WORDS && cyc < 300) begin
      if (w == abort_at) begin
        mem_rvalid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_mem_req", mem_req, 0);
        chk("abort_wr_enable", wr_enable, 0);
        chk("abort_WD", WD, 0);
        chk("abort_RD", RD, 0);
        last_rd = '0;
        last_wd = '0;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        return;
      end
      chk("fetch_req", mem_req, 1);
      chk("fetch_addr", mem_addr, addr[w]);
      chk("fetch_no_write", wr_enable, 0);
      if (waited == wt[w]) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_word(addr[w], salt);
        w++;
        waited = 0;
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        waited++;
      end
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    chk("write_latency", cyc, exp_cyc);
    chk("write_wr_enable", wr_enable, 1);
    chk("write_done", done, 1);
    chk("write_busy", busy, 1);
    chk("write_mem_req", mem_req, 0);
    chk("write_RD", RD, dest);
    chk("write_WD", WD, exp_wd);
    last_rd = dest;
    last_wd = exp_wd;
    // Stray read data outside FETCH must be ignored.
    mem_rvalid = 1'b1;
    mem_rdata  = $urandom;
    @(posedge clk); @(negedge clk);
    chk("after_busy", busy, 0);
    chk("after_wr_enable", wr_enable, 0);
    chk("after_done", done, 0);
    chk("after_RD_hold", RD, last_rd);
    chk("after_WD_hold", WD, last_wd);
  endtask

  logic [ADDR_W-1:0] sa;

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_mem_req", mem_req, 0);
    chk("reset_wr_enable", wr_enable, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_RD", RD, 0);
    chk("reset_WD", WD, 0);
    rst = 1'b0;
    @(negedge clk);

    // zero-wait contiguous load
    run_load(32'h100, 32'd4, 4'd7, 0, 1'b0, -1);
    // one wait cycle per word
    run_load(32'h2000, 32'd4, 4'd4, -1, 1'b0, -1);
    // start held high across back-to-back loads
    run_load(32'h300, 32'd4, 4'd1, 1, 1'b1, -1);
    run_load(32'h400, 32'd4, 4'd2, 0, 1'b1, -1);
    run_load(32'h500, 32'd4, 4'd3, 2, 1'b0, -1);
    // reset after word 3 captured, then a clean restart
    run_load(32'h600, 32'd4, 4'd9, 1, 1'b0, 4);
    chk("restart_idle", busy, 0);
    run_load(32'h700, 32'd4, 4'd9, 0, 1'b0, -1);
    // address wrap at the top of the address space
    run_load(32'hFFFF_FFF8, 32'd4, 4'd15, 0, 1'b0, -1);
    // destination register 0
    run_load(32'h40, 32'd4, 4'd0, 1, 1'b0, -1);

`ifdef VLOAD_STRIDE_EN
    run_load(32'h0, 32'h20, 4'd5, 0, 1'b0, -1);
    run_load(32'h1234, 32'h0, 4'd6, 2, 1'b0, -1);
    for (int k = 0; k < 10; k++) begin
      sa = $urandom;
      run_load(sa, $urandom, REG_ADDR_W'($urandom), 3, 1'($urandom_range(0, 1)), -1);
      start = 1'b0;
    end
`endif

    for (int k = 0; k < 25; k++) begin
      sa = $urandom;
      sa[1:0] = 2'b00;
      run_load(sa, 32'd4, REG_ADDR_W'($urandom), 3, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, WORDS - 1)) : -1);
      start = 1'b0;
      if (busy) chk("loop_idle", busy, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
